// File: rtl/bcd_sync_counter.sv
// Synchronous multi-digit BCD up/down counter with validated parallel load
// and a combinational terminal-count output for cascading instances.
module bcd_sync_counter #(
    parameter int DIGITS = 2
) (
    input  logic                  CK,
    input  logic                  Clear,
    input  logic                  En,
    input  logic                  Up,
    input  logic                  Load,
    input  logic [4*DIGITS-1:0]   D,
    output logic [4*DIGITS-1:0]   Q,
    output logic                  TC,
    output logic                  LoadErr
);

    localparam int W = 4 * DIGITS;

    logic [W-1:0] q_q, q_d;
    logic         err_q, err_d;
    logic [W-1:0] step_val;
    logic         load_ok;
    logic         all_nine;
    logic         all_zero;
    logic         carry;
    logic [3:0]   dig;

    always_comb begin
        load_ok  = 1'b1;
        all_nine = 1'b1;
        all_zero = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (D[4*i +: 4] > 4'd9)    load_ok  = 1'b0;
            if (q_q[4*i +: 4] != 4'd9) all_nine = 1'b0;
            if (q_q[4*i +: 4] != 4'd0) all_zero = 1'b0;
        end
    end

    // Ripple the carry/borrow through the digits combinationally; every digit
    // still updates on the same edge.
    always_comb begin
        step_val = q_q;
        carry    = 1'b1;
        dig      = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            dig = q_q[4*i +: 4];
            if (carry) begin
                if (Up) begin
                    if (dig == 4'd9) begin
                        step_val[4*i +: 4] = 4'd0;
                    end else begin
                        step_val[4*i +: 4] = dig + 4'd1;
                        carry              = 1'b0;
                    end
                end else begin
                    if (dig == 4'd0) begin
                        step_val[4*i +: 4] = 4'd9;
                    end else begin
                        step_val[4*i +: 4] = dig - 4'd1;
                        carry              = 1'b0;
                    end
                end
            end
        end
    end

    always_comb begin
        q_d   = q_q;
        err_d = 1'b0;
        if (Load) begin
            if (load_ok) q_d   = D;
            else         err_d = 1'b1;
        end else if (En) begin
            q_d = step_val;
        end
    end

    always_ff @(posedge CK or posedge Clear) begin
        if (Clear) begin
            q_q   <= '0;
            err_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            err_q <= err_d;
        end
    end

    assign TC      = En & ~Load & (Up ? all_nine : all_zero);
    assign Q       = q_q;
    assign LoadErr = err_q;

endmodule

// File: tb/tb_bcd_sync_counter.sv
// Bench for bcd_sync_counter: a 2-digit instance and a cascaded pair of
// 1-digit instances, both checked edge by edge against an integer model.
module tb_bcd_sync_counter;

    logic       CK = 1'b0;
    logic       Clear;
    logic       En, Up, Load;
    logic [7:0] D;
    logic       c_en, c_load;

    logic [7:0] Q;
    logic       TC, LoadErr;
    logic [3:0] q_lo, q_hi;
    logic       tc_lo, tc_hi, err_lo, err_hi;

    int n_checks = 0;
    int n_errors = 0;

    int m_val;
    bit m_err;

    always #5 CK = ~CK;

    bcd_sync_counter #(.DIGITS(2)) dut (
        .CK(CK), .Clear(Clear), .En(En), .Up(Up), .Load(Load),
        .D(D), .Q(Q), .TC(TC), .LoadErr(LoadErr)
    );

    bcd_sync_counter #(.DIGITS(1)) u_lo (
        .CK(CK), .Clear(Clear), .En(c_en), .Up(Up), .Load(c_load),
        .D(D[3:0]), .Q(q_lo), .TC(tc_lo), .LoadErr(err_lo)
    );

    bcd_sync_counter #(.DIGITS(1)) u_hi (
        .CK(CK), .Clear(Clear), .En(tc_lo), .Up(Up), .Load(c_load),
        .D(D[7:4]), .Q(q_hi), .TC(tc_hi), .LoadErr(err_hi)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] to_bcd(input int v);
        logic [3:0] t, u;
        t = 4'(v / 10);
        u = 4'(v % 10);
        return {t, u};
    endfunction

    function automatic bit d_valid(input logic [7:0] d);
        return (d[3:0] <= 4'd9) && (d[7:4] <= 4'd9);
    endfunction

    function automatic int d_dec(input logic [7:0] d);
        return int'(d[7:4]) * 10 + int'(d[3:0]);
    endfunction

    // The chained pair has no single-digit notion of rejecting the other
    // digit's nibble, so it sees a rejected load as an idle cycle.
    task automatic step(input logic en, input logic up, input logic ld, input logic [7:0] d);
        bit exp_tc;
        En   = en;
        Up   = up;
        Load = ld;
        D    = d;
        c_load = ld & d_valid(d);
        c_en   = (ld & ~d_valid(d)) ? 1'b0 : en;
        exp_tc = en && !ld && (up ? (m_val == 99) : (m_val == 0));
        @(negedge CK);
        chk("tc", 32'(TC), 32'(exp_tc));
        @(posedge CK);
        if (ld) begin
            if (d_valid(d)) begin
                m_val = d_dec(d);
                m_err = 1'b0;
            end else begin
                m_err = 1'b1;
            end
        end else begin
            m_err = 1'b0;
            if (en) m_val = up ? (m_val + 1) % 100 : (m_val + 99) % 100;
        end
        #1;
        chk("q", 32'(Q), 32'(to_bcd(m_val)));
        chk("loaderr", 32'(LoadErr), 32'(m_err));
        chk("cascade_q", 32'({q_hi, q_lo}), 32'(to_bcd(m_val)));
    endtask

    // Called right after a step, so the pulse lands well before the next edge.
    task automatic clear_pulse();
        En = 1'b0; Load = 1'b0; c_en = 1'b0; c_load = 1'b0;
        #1 Clear = 1'b1;
        #1;
        m_val = 0;
        m_err = 1'b0;
        chk("clear_q", 32'(Q), 32'h00);
        chk("clear_err", 32'(LoadErr), 32'h0);
        chk("clear_cascade", 32'({q_hi, q_lo}), 32'h00);
        #1 Clear = 1'b0;
    endtask

    initial begin
        logic [7:0] rd;
        Clear = 1'b1; En = 1'b0; Up = 1'b1; Load = 1'b0; D = 8'h00;
        c_en = 1'b0; c_load = 1'b0;
        m_val = 0; m_err = 1'b0;
        #2;
        chk("reset_q", 32'(Q), 32'h00);
        chk("reset_err", 32'(LoadErr), 32'h0);
        @(posedge CK);
        #1 Clear = 1'b0;

        step(1'b0, 1'b1, 1'b1, 8'h37);
        clear_pulse();
        step(1'b1, 1'b1, 1'b0, 8'h00);
        chk("after_clear_01", 32'(Q), 32'h01);

        clear_pulse();
        for (int i = 0; i < 100; i++) step(1'b1, 1'b1, 1'b0, 8'h00);
        chk("up_wrap_00", 32'(Q), 32'h00);

        step(1'b0, 1'b0, 1'b1, 8'h01);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        chk("down_wrap_99", 32'(Q), 32'h99);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b1, 8'h10);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        chk("borrow_09", 32'(Q), 32'h09);

        step(1'b1, 1'b1, 1'b1, 8'h57);
        chk("load_no_count", 32'(Q), 32'h57);
        step(1'b1, 1'b1, 1'b0, 8'h00);
        chk("load_then_58", 32'(Q), 32'h58);

        step(1'b0, 1'b1, 1'b1, 8'h42);
        step(1'b1, 1'b1, 1'b1, 8'h5A);
        chk("bad_load_hold", 32'(Q), 32'h42);
        chk("bad_load_err", 32'(LoadErr), 32'h1);
        step(1'b0, 1'b1, 1'b0, 8'h00);
        chk("err_one_cycle", 32'(LoadErr), 32'h0);

        step(1'b0, 1'b1, 1'b1, 8'h98);
        step(1'b1, 1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b1, 1'b0, 8'h00);
        chk("cascade_wrap", 32'({q_hi, q_lo}), 32'h00);
        step(1'b0, 1'b0, 1'b0, 8'h00);

        step(1'b0, 1'b1, 1'b1, 8'h00);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        chk("dir_change_99", 32'(Q), 32'h99);

        for (int i = 0; i < 400; i++) begin
            rd = ($urandom_range(0, 3) == 0) ? 8'($urandom) : to_bcd($urandom_range(0, 99));
            step(1'($urandom_range(0, 3) != 0), 1'($urandom),
                 1'($urandom_range(0, 7) == 0), rd);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout t=%0t", $time);
        $fatal(1, "timeout");
    end

endmodule
